if_fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of Instruction_Memory and drives its Inst_Address. It owns the program counter and issues one word address per cycle. It captures the returned 32-bit instruction into an IF/ID register and presents it to decode with a valid/ready handshake. It also handles branch redirect/flush, decode back-pressure and fetch faults (misaligned or out-of-range address).

---
 rtl/riscv_pkg.sv | 17 +
 rtl/if_fetch_stage_if.sv | 42 ++++
 rtl/if_fetch_stage_if_id_reg.sv | 48 ++++
 rtl/if_fetch_stage.sv | 93 +++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch constants, fault codes and fetch state type
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  localparam int unsigned PC_INCR = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - memory, redirect and decode-side signals of the fetch stage
interface if_fetch_stage_if #(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
);
  logic [PC_WIDTH-1:0]    inst_address;
  logic [INSTR_WIDTH-1:0] instruction_in;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_target;
  logic                   id_ready;
  logic                   id_valid;
  logic [PC_WIDTH-1:0]    id_pc;
  logic [PC_WIDTH-1:0]    id_pc_plus4;
  logic [INSTR_WIDTH-1:0] id_instruction;
  logic [1:0]             fault_code;

  modport master (
    output inst_address,
    input  instruction_in,
    input  branch_taken,
    input  branch_target,
    input  id_ready,
    output id_valid,
    output id_pc,
    output id_pc_plus4,
    output id_instruction,
    output fault_code
  );

  modport slave (
    input  inst_address,
    output instruction_in,
    output branch_taken,
    output branch_target,
    output id_ready,
    input  id_valid,
    input  id_pc,
    input  id_pc_plus4,
    input  id_instruction,
    input  fault_code
  );
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// rtl/if_fetch_stage_if_id_reg.sv - IF/ID pipeline register with load and flush
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   flush_i,
  input  logic [PC_WIDTH-1:0]    pc_i,
  input  logic [PC_WIDTH-1:0]    pc_plus4_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic                   valid_o,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic [PC_WIDTH-1:0]    pc_plus4_o,
  output logic [INSTR_WIDTH-1:0] instr_o
);

  logic                   valid_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    pc_plus4_q;
  logic [INSTR_WIDTH-1:0] instr_q;

  // Flush only drops valid; the payload holds so a flushed entry never glitches id_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= INSTR_WIDTH'(NOP_INSTR);
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
      instr_q    <= instr_i;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC, redirect priority and fault FSM feeding the IF/ID register
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned         MEM_BYTES   = 16
) (
  input  logic       clk,
  input  logic       reset,
  if_fetch_stage_if.master fetch
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]          fault_q, fault_d;

  logic                id_valid;
  logic                capture;
  logic                misalign;
  logic                out_of_range;
  logic                load;
  logic                flush;
  logic [PC_WIDTH:0]   end_addr;
  logic [PC_WIDTH-1:0] pc_plus4;

  // Extra top bit keeps a PC near the top of the address space from wrapping into range.
  assign end_addr     = {1'b0, pc_q} + (PC_WIDTH+1)'(3);
  assign out_of_range = end_addr >= (PC_WIDTH+1)'(MEM_BYTES);
  assign pc_plus4     = pc_q + PC_WIDTH'(PC_INCR);
  assign capture      = !id_valid || fetch.id_ready;
  assign misalign     = fetch.branch_taken && (fetch.branch_target[1:0] != 2'b00);

  assign load  = (state_q == RUN) && !fetch.branch_taken && capture && !out_of_range;
  assign flush = (state_q != RUN) || fetch.branch_taken || (capture && out_of_range);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (state_q == RUN) begin
      if (misalign) begin
        pc_d    = fetch.branch_target;
        fault_d = FAULT_MISALIGN;
        state_d = FAULT;
      end else if (fetch.branch_taken) begin
        pc_d = fetch.branch_target;
      end else if (capture) begin
        if (out_of_range) begin
          fault_d = FAULT_RANGE;
          state_d = FAULT;
        end else begin
          pc_d = pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (load),
    .flush_i    (flush),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_i    (fetch.instruction_in),
    .valid_o    (id_valid),
    .pc_o       (fetch.id_pc),
    .pc_plus4_o (fetch.id_pc_plus4),
    .instr_o    (fetch.id_instruction)
  );

  assign fetch.id_valid     = id_valid;
  assign fetch.inst_address = pc_q;
  assign fetch.fault_code   = fault_q;

endmodule
